// File: rtl/rx_frame_sequencer_pkg.sv
// Shared constants and types for the receive frame sequencer.
// Control byte values are reserved and never carried as REF/PAYLOAD data.
package rx_frame_sequencer_pkg;

    localparam logic [7:0] FRAME_HEADSTART = 8'hC3;
    localparam logic [7:0] FRAME_START     = 8'h3C;
    localparam logic [7:0] FRAME_END       = 8'h5A;

    typedef enum logic [2:0] {
        SEQ_HUNT,
        SEQ_HEAD,
        SEQ_DATA,
        SEQ_HOLD
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_SHORT,
        ERR_LONG,
        ERR_RESYNC,
        ERR_TIMEOUT
    } seq_err_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_frame_sequencer_byte_aligner.sv
// Bit-serial shifter: hunts for the head-start pattern bit by bit,
// then frames whole bytes once locked.
module byte_aligner
    import rx_frame_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic       i_bit,
    input  logic       i_locked,
    input  logic       i_clear,
    output logic       o_byte_done,
    output logic       o_hunt_hit,
    output logic [7:0] o_byte
);

    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic [7:0] w_next;

    assign w_next      = {r_shift[6:0], i_bit};
    assign o_byte      = w_next;
    assign o_byte_done = i_valid && i_locked && (r_cnt == 3'd7);
    assign o_hunt_hit  = i_valid && !i_locked && (w_next == FRAME_HEADSTART);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= w_next;
            r_cnt   <= i_locked ? r_cnt + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive frame sequencer: aligns bytes, counts REF/PAYLOAD fields,
// checks framing and holds a completed frame until acknowledged.
module rx_frame_sequencer
    import rx_frame_sequencer_pkg::*;
#(
    parameter int REF_BYTES      = 2,
    parameter int PAYLOAD_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic       sym_bit,
    output logic       hdr_we,
    output logic       data_we,
    output logic [7:0] byte_out,
    output logic       buf_clr,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] overrun_cnt
);

    localparam int FW = $clog2(max_int(REF_BYTES, PAYLOAD_BYTES) + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] REF_N    = FW'(REF_BYTES);
    localparam logic [FW-1:0] PAY_N    = FW'(PAYLOAD_BYTES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    r_state, w_state_nx;
    seq_err_t      r_code, w_code_nx, w_fcode;
    logic [FW-1:0] r_field, w_field_nx;
    logic [TW-1:0] r_tmo, w_tmo_nx;
    logic [7:0]    r_byte, w_byte_nx;
    logic [7:0]    r_ovr, w_ovr_nx;
    logic          r_hdr, w_hdr_nx;
    logic          r_data, w_data_nx;
    logic          r_clr, w_clr_nx;
    logic          r_err, w_err_nx;
    logic          r_fv, w_fv_nx;
    logic          w_fail, w_aln_clr;
    logic          w_aln_valid, w_locked;
    logic          w_byte_done, w_hunt_hit;
    logic [7:0]    w_byte;

    // Bits arriving while a frame is held are dropped, never shifted.
    assign w_aln_valid = sym_valid && (r_state != SEQ_HOLD);
    assign w_locked    = (r_state == SEQ_HEAD) || (r_state == SEQ_DATA);

    byte_aligner u_aligner (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (w_aln_valid),
        .i_bit       (sym_bit),
        .i_locked    (w_locked),
        .i_clear     (w_aln_clr),
        .o_byte_done (w_byte_done),
        .o_hunt_hit  (w_hunt_hit),
        .o_byte      (w_byte)
    );

    always_comb begin
        w_state_nx = r_state;
        w_field_nx = r_field;
        w_tmo_nx   = r_tmo;
        w_byte_nx  = r_byte;
        w_ovr_nx   = r_ovr;
        w_code_nx  = r_code;
        w_fv_nx    = r_fv;
        w_hdr_nx   = 1'b0;
        w_data_nx  = 1'b0;
        w_clr_nx   = 1'b0;
        w_err_nx   = 1'b0;
        w_fail     = 1'b0;
        w_fcode    = ERR_NONE;
        w_aln_clr  = 1'b0;
        unique case (r_state)
            SEQ_HUNT: begin
                if (w_hunt_hit) begin
                    w_state_nx = SEQ_HEAD;
                    w_field_nx = '0;
                    w_tmo_nx   = '0;
                end
            end
            SEQ_HEAD, SEQ_DATA: begin
                if (sym_valid) begin
                    w_tmo_nx = '0;
                end else if (r_tmo == TMO_LAST) begin
                    w_fail     = 1'b1;
                    w_fcode    = ERR_TIMEOUT;
                    w_state_nx = SEQ_HUNT;
                    w_aln_clr  = 1'b1;
                    w_tmo_nx   = '0;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
                if (w_byte_done) begin
                    w_byte_nx = w_byte;
                    if (r_state == SEQ_HEAD) begin
                        unique case (1'b1)
                            (w_byte == FRAME_HEADSTART): begin
                                w_fail     = 1'b1;
                                w_fcode    = ERR_RESYNC;
                                w_field_nx = '0;
                            end
                            (w_byte == FRAME_START): begin
                                if (r_field == REF_N) begin
                                    w_state_nx = SEQ_DATA;
                                    w_field_nx = '0;
                                end else begin
                                    w_fail     = 1'b1;
                                    w_fcode    = ERR_SHORT;
                                    w_state_nx = SEQ_HUNT;
                                end
                            end
                            (w_byte == FRAME_END): begin
                                w_fail     = 1'b1;
                                w_fcode    = ERR_SHORT;
                                w_state_nx = SEQ_HUNT;
                            end
                            default: begin
                                if (r_field < REF_N) begin
                                    w_hdr_nx   = 1'b1;
                                    w_field_nx = r_field + 1'b1;
                                end else begin
                                    w_fail     = 1'b1;
                                    w_fcode    = ERR_LONG;
                                    w_state_nx = SEQ_HUNT;
                                end
                            end
                        endcase
                    end else begin
                        unique case (1'b1)
                            (w_byte == FRAME_END): begin
                                if (r_field == PAY_N) begin
                                    w_state_nx = SEQ_HOLD;
                                    w_fv_nx    = 1'b1;
                                end else begin
                                    w_fail     = 1'b1;
                                    w_fcode    = ERR_SHORT;
                                    w_state_nx = SEQ_HUNT;
                                end
                            end
                            (w_byte == FRAME_HEADSTART): begin
                                w_fail     = 1'b1;
                                w_fcode    = ERR_RESYNC;
                                w_state_nx = SEQ_HEAD;
                                w_field_nx = '0;
                            end
                            (w_byte == FRAME_START): begin
                                w_fail     = 1'b1;
                                w_fcode    = ERR_LONG;
                                w_state_nx = SEQ_HUNT;
                            end
                            default: begin
                                if (r_field < PAY_N) begin
                                    w_data_nx  = 1'b1;
                                    w_field_nx = r_field + 1'b1;
                                end else begin
                                    w_fail     = 1'b1;
                                    w_fcode    = ERR_LONG;
                                    w_state_nx = SEQ_HUNT;
                                end
                            end
                        endcase
                    end
                end
            end
            SEQ_HOLD: begin
                if (sym_valid && (r_ovr != 8'hFF)) begin
                    w_ovr_nx = r_ovr + 8'd1;
                end
                if (frame_ack) begin
                    w_fv_nx    = 1'b0;
                    w_state_nx = SEQ_HUNT;
                    w_aln_clr  = 1'b1;
                end
            end
            default: w_state_nx = SEQ_HUNT;
        endcase
        // Any error suppresses the strobe of the byte that caused it.
        if (w_fail) begin
            w_err_nx  = 1'b1;
            w_clr_nx  = 1'b1;
            w_code_nx = w_fcode;
            w_hdr_nx  = 1'b0;
            w_data_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEQ_HUNT;
            r_field <= '0;
            r_tmo   <= '0;
            r_byte  <= '0;
            r_ovr   <= '0;
            r_code  <= ERR_NONE;
            r_fv    <= 1'b0;
            r_hdr   <= 1'b0;
            r_data  <= 1'b0;
            r_clr   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_field <= w_field_nx;
            r_tmo   <= w_tmo_nx;
            r_byte  <= w_byte_nx;
            r_ovr   <= w_ovr_nx;
            r_code  <= w_code_nx;
            r_fv    <= w_fv_nx;
            r_hdr   <= w_hdr_nx;
            r_data  <= w_data_nx;
            r_clr   <= w_clr_nx;
            r_err   <= w_err_nx;
        end
    end

    assign hdr_we      = r_hdr;
    assign data_we     = r_data;
    assign byte_out    = r_byte;
    assign buf_clr     = r_clr;
    assign frame_valid = r_fv;
    assign err         = r_err;
    assign err_code    = r_code;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: directed frames plus a random bit stream,
// all outputs compared every cycle against a frame-level reference model.
module tb_rx_frame_sequencer;
    import rx_frame_sequencer_pkg::*;

    localparam int REF = 2;
    localparam int PAY = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_bit = 1'b0;
    logic       frame_ack = 1'b0;
    logic       hdr_we, data_we, buf_clr, frame_valid, err;
    logic [7:0] byte_out, overrun_cnt;
    logic [2:0] err_code;

    always #5 clk = ~clk;

    rx_frame_sequencer #(
        .REF_BYTES      (REF),
        .PAYLOAD_BYTES  (PAY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym_valid   (sym_valid),
        .sym_bit     (sym_bit),
        .hdr_we      (hdr_we),
        .data_we     (data_we),
        .byte_out    (byte_out),
        .buf_clr     (buf_clr),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err         (err),
        .err_code    (err_code),
        .overrun_cnt (overrun_cnt)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame phases, field counts and idle time.
    localparam int M_HUNT = 0, M_HEAD = 1, M_DATA = 2, M_HOLD = 3;
    int         m_mode, m_nb, m_nf, m_idle, e_ovr;
    logic [7:0] m_sh, e_byte;
    logic [2:0] e_code;
    logic       e_hdr, e_data, e_clr, e_err, e_fv;

    task automatic m_reset();
        m_mode = M_HUNT; m_nb = 0; m_nf = 0; m_idle = 0; e_ovr = 0;
        m_sh = 0; e_byte = 0; e_code = 0;
        e_hdr = 0; e_data = 0; e_clr = 0; e_err = 0; e_fv = 0;
    endtask

    task automatic m_fail(input int code, input int nxt);
        e_err = 1; e_clr = 1; e_code = 3'(code); m_mode = nxt;
    endtask

    task automatic m_byte(input logic [7:0] x);
        e_byte = x;
        if (m_mode == M_HEAD) begin
            if (x == FRAME_HEADSTART) begin m_fail(3, M_HEAD); m_nf = 0; end
            else if (x == FRAME_START) begin
                if (m_nf == REF) begin m_mode = M_DATA; m_nf = 0; end
                else m_fail(1, M_HUNT);
            end
            else if (x == FRAME_END) m_fail(1, M_HUNT);
            else if (m_nf < REF) begin e_hdr = 1; m_nf++; end
            else m_fail(2, M_HUNT);
        end else begin
            if (x == FRAME_END) begin
                if (m_nf == PAY) begin m_mode = M_HOLD; e_fv = 1; end
                else m_fail(1, M_HUNT);
            end
            else if (x == FRAME_HEADSTART) begin m_fail(3, M_HEAD); m_nf = 0; end
            else if (x == FRAME_START) m_fail(2, M_HUNT);
            else if (m_nf < PAY) begin e_data = 1; m_nf++; end
            else m_fail(2, M_HUNT);
        end
    endtask

    task automatic m_step(input logic v, input logic b, input logic a);
        e_hdr = 0; e_data = 0; e_clr = 0; e_err = 0;
        if (m_mode == M_HUNT) begin
            if (v) begin
                m_sh = {m_sh[6:0], b};
                if (m_sh == FRAME_HEADSTART) begin
                    m_mode = M_HEAD; m_nb = 0; m_nf = 0; m_idle = 0;
                end
            end
        end else if (m_mode == M_HOLD) begin
            if (v && e_ovr < 255) e_ovr++;
            if (a) begin e_fv = 0; m_mode = M_HUNT; m_sh = 0; m_nb = 0; end
        end else if (v) begin
            m_idle = 0;
            m_sh = {m_sh[6:0], b};
            m_nb++;
            if (m_nb == 8) begin m_nb = 0; m_byte(m_sh); end
        end else begin
            m_idle++;
            if (m_idle >= TMO) begin
                m_fail(4, M_HUNT); m_sh = 0; m_nb = 0; m_idle = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step(sym_valid, sym_bit, frame_ack);
    end

    always @(negedge clk) begin
        check("cycle",
              {8'd0, hdr_we, data_we, byte_out, buf_clr, frame_valid, err,
               err_code, overrun_cnt},
              {8'd0, e_hdr, e_data, e_byte, e_clr, e_fv, e_err, e_code,
               e_ovr[7:0]});
    end

    logic [7:0] hq[$];
    logic [7:0] dq[$];
    logic [2:0] eq[$];
    int         nclr = 0;

    always @(negedge clk) begin
        if (hdr_we) hq.push_back(byte_out);
        if (data_we) dq.push_back(byte_out);
        if (err) eq.push_back(err_code);
        if (buf_clr) nclr++;
    end

    task automatic drive(input logic v, input logic b, input logic a);
        @(negedge clk);
        sym_valid = v; sym_bit = b; frame_ack = a;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        for (int i = 7; i >= 0; i--) begin
            drive(1, d[i], 0);
            idle(gap);
        end
    endtask

    task automatic send_frame(input int npay, input int gap);
        send_byte(FRAME_HEADSTART, gap);
        send_byte(8'h12, gap);
        send_byte(8'h34, gap);
        send_byte(FRAME_START, gap);
        for (int i = 0; i < npay; i++) send_byte(8'hA1 + 8'(i), gap);
        send_byte(FRAME_END, gap);
    endtask

    task automatic ack();
        drive(0, 0, 1);
        check("ack_fv_before", 32'(frame_valid), 1);
        drive(0, 0, 0);
        check("ack_fv_after", 32'(frame_valid), 0);
    endtask

    function automatic logic [7:0] qat(input int which, input int i);
        if (which == 0) return (i < hq.size()) ? hq[i] : 8'hEE;
        if (which == 1) return (i < dq.size()) ? dq[i] : 8'hEE;
        return (i < eq.size()) ? 8'(eq[i]) : 8'hEE;
    endfunction

    function automatic logic [7:0] rbyte();
        logic [7:0] r;
        r = 8'($urandom);
        case ($urandom_range(0, 23))
            0: r = FRAME_HEADSTART;
            1: r = FRAME_START;
            2: r = FRAME_END;
            default: ;
        endcase
        return r;
    endfunction

    int h0, d0, e0, c0;

    task automatic mark();
        h0 = hq.size(); d0 = dq.size(); e0 = eq.size(); c0 = nclr;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("reset_outs",
              {13'd0, hdr_we, data_we, byte_out, buf_clr, frame_valid, err,
               err_code, overrun_cnt}, 0);

        // Good frame after junk bits.
        mark();
        repeat (3) drive(1, 1'($urandom_range(0, 1)), 0);
        send_frame(4, 0);
        idle(3);
        check("t1_hdr_n", hq.size() - h0, 2);
        check("t1_hdr0", qat(0, h0), 8'h12);
        check("t1_hdr1", qat(0, h0 + 1), 8'h34);
        check("t1_data_n", dq.size() - d0, 4);
        for (int i = 0; i < 4; i++)
            check("t1_data", qat(1, d0 + i), 8'hA1 + 8'(i));
        check("t1_fv", 32'(frame_valid), 1);
        check("t1_noerr", eq.size() - e0, 0);
        ack();

        // Short payload.
        mark();
        send_frame(3, 0);
        idle(3);
        check("t2_short_n", eq.size() - e0, 1);
        check("t2_short_code", qat(2, e0), 1);
        check("t2_short_clr", nclr - c0, 1);
        check("t2_short_data", dq.size() - d0, 3);

        // Long payload: fifth data byte rejected.
        mark();
        send_byte(FRAME_HEADSTART, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(FRAME_START, 0);
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), 0);
        idle(3);
        check("t2_long_code", qat(2, e0), 2);
        check("t2_long_data", dq.size() - d0, 4);

        // Resync in DATA, then rest of a good frame.
        mark();
        send_byte(FRAME_HEADSTART, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(FRAME_START, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        send_byte(FRAME_HEADSTART, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(FRAME_START, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i), 0);
        send_byte(FRAME_END, 0);
        idle(3);
        check("t3_err_n", eq.size() - e0, 1);
        check("t3_code", qat(2, e0), 3);
        check("t3_fv", 32'(frame_valid), 1);
        check("t3_data", dq.size() - d0, 6);
        ack();

        // Timeout in HEAD; a bit on the boundary cycle rescues it.
        mark();
        send_byte(FRAME_HEADSTART, 0);
        idle(TMO - 1);
        drive(1, 0, 0);
        idle(2);
        check("t4_boundary", eq.size() - e0, 0);
        idle(TMO + 1);
        check("t4_err_n", eq.size() - e0, 1);
        check("t4_code", qat(2, e0), 4);
        check("t4_clr", nclr - c0, 1);

        // Overrun while holding a frame.
        send_frame(4, 0);
        idle(2);
        repeat (10) begin
            drive(1, 1'($urandom_range(0, 1)), 0);
            idle(1);
        end
        idle(2);
        check("t5_ovr", 32'(overrun_cnt), 10);
        check("t5_fv", 32'(frame_valid), 1);
        ack();
        mark();
        send_frame(4, 1);
        idle(3);
        check("t5_refind", 32'(frame_valid), 1);
        check("t5_hdr", hq.size() - h0, 2);
        ack();

        // Asynchronous reset mid-frame.
        mark();
        send_byte(FRAME_HEADSTART, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(FRAME_START, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        repeat (3) drive(1, 1, 0);
        #2 rst_n = 1'b0;
        #1 check("t6_async",
                 {13'd0, hdr_we, data_we, byte_out, buf_clr, frame_valid, err,
                  err_code, overrun_cnt}, 0);
        @(negedge clk);
        sym_valid = 0;
        rst_n = 1'b1;
        idle(3);
        check("t6_noerr", eq.size() - e0, 0);
        send_frame(4, 0);
        idle(3);
        check("t6_fv", 32'(frame_valid), 1);
        ack();

        // Random streams of mostly-framed bits.
        for (int f = 0; f < 60; f++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat ($urandom_range(0, 12))
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 9) == 0);
            send_byte(FRAME_HEADSTART, gap);
            repeat ($urandom_range(1, 3)) send_byte(rbyte(), gap);
            if ($urandom_range(0, 7) != 0) send_byte(FRAME_START, gap);
            repeat ($urandom_range(3, 5)) send_byte(rbyte(), gap);
            send_byte(FRAME_END, gap);
            case ($urandom_range(0, 3))
                0: idle(TMO - 2 + $urandom_range(0, 4));
                1: repeat ($urandom_range(1, 6)) drive(1, 0, 0);
                default: idle(2);
            endcase
            if ($urandom_range(0, 3) != 0) drive(0, 0, 1);
            idle(1);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
